// File: rtl/ctrl_result_deskew_pkg.sv
// Shared constants and helpers for the result deskew block.
// Lane packing: lane i of any row vector sits at bits [i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW].
package ctrl_result_deskew_pkg;

    localparam int PARTIAL_SUM_BW = 19;
    localparam int NUM_PE_ROWS    = 8;
    localparam int MATRIX_SIZE    = 8;
    localparam int FIFO_DEPTH     = 4;

    localparam int VEC_W     = NUM_PE_ROWS * PARTIAL_SUM_BW;
    localparam int ROW_IDX_W = $clog2(MATRIX_SIZE);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W   = VEC_W + ROW_IDX_W + 1;

    // Extract one lane from a packed row vector.
    function automatic logic [PARTIAL_SUM_BW-1:0] laneSlice(input logic [VEC_W-1:0] vec,
                                                             input int lane);
        return PARTIAL_SUM_BW'(vec >> (lane * PARTIAL_SUM_BW));
    endfunction

endpackage

// File: rtl/ctrl_result_fifo.sv
// Synchronous FIFO for aligned result rows. Accepts a push while full
// when the head is popped in the same cycle; otherwise a push while full is
// refused and reported on drop_o. Reads present zero while empty.
module ctrl_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           pushData_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full, pop, pushOk;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign pop    = !empty && ready_i;
    assign pushOk = push_i && (!full || pop);
    assign drop_o = push_i && full && !pop;

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rdPtr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
        if (pop)    rdPtr_d = rdPtr_q + 1'b1;
        unique case ({pushOk, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by reset or clr.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: empty slots are masked on the read side.
    always_ff @(posedge clk_i) begin
        if (pushOk) mem_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/ctrl_result_deskew.sv
// Realigns skewed systolic-array results into one row vector per cycle,
// tags each row with its position in the tile and buffers it for write-back.
// Optional macro RESULT_DESKEW_RELU_EN clamps negative lanes to zero before buffering.
module ctrl_result_deskew
    import ctrl_result_deskew_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [VEC_W-1:0]     result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VEC_W-1:0]     out_data,
    output logic [ROW_IDX_W-1:0] out_row_idx,
    output logic                 out_last,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 overflow
);

    localparam int VDEPTH = NUM_PE_ROWS - 1;

    logic [VDEPTH-1:0]    validPipe_q;
    logic                 av;
    logic [VEC_W-1:0]     pushVec;
    logic [ROW_IDX_W-1:0] rowCnt_q, rowCnt_d;
    logic                 rowLast;
    logic                 overflow_q, overflow_d;
    logic                 fifoDrop;
    logic [ENTRY_W-1:0]   fifoOut;

    // Valid follows lane 0 through the same number of stages as the deepest lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     validPipe_q <= '0;
        else if (clr)  validPipe_q <= '0;
        else           validPipe_q <= {validPipe_q[VDEPTH-2:0], in_valid};
    end

    assign av = validPipe_q[VDEPTH-1];

    for (genvar lane = 0; lane < NUM_PE_ROWS; lane++) begin : gLane
        localparam int DELAY = NUM_PE_ROWS - 1 - lane;
        logic [PARTIAL_SUM_BW-1:0] alignedLane;
        logic [PARTIAL_SUM_BW-1:0] pushLane;

        if (DELAY == 0) begin : gDirect
            assign alignedLane = laneSlice(result, lane);
        end else begin : gDelay
            logic [PARTIAL_SUM_BW-1:0] stage_q [DELAY];

            // Early lanes wait here until the last lane catches up.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    stage_q <= '{default: '0};
                end else if (clr) begin
                    stage_q <= '{default: '0};
                end else begin
                    stage_q[0] <= laneSlice(result, lane);
                    for (int s = 1; s < DELAY; s++) stage_q[s] <= stage_q[s-1];
                end
            end

            assign alignedLane = stage_q[DELAY-1];
        end

`ifdef RESULT_DESKEW_RELU_EN
        assign pushLane = alignedLane[PARTIAL_SUM_BW-1] ? '0 : alignedLane;
`else
        assign pushLane = alignedLane;
`endif
        assign pushVec[lane*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = pushLane;
    end

    assign rowLast = (rowCnt_q == ROW_IDX_W'(MATRIX_SIZE - 1));

    // Row position advances on every aligned vector, whether buffered or dropped.
    always_comb begin
        rowCnt_d   = rowCnt_q;
        overflow_d = overflow_q | fifoDrop;
        if (av) rowCnt_d = rowLast ? '0 : rowCnt_q + 1'b1;
    end

    // Row counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rowCnt_q   <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            rowCnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rowCnt_q   <= rowCnt_d;
            overflow_q <= overflow_d;
        end
    end

    ctrl_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .clr_i      (clr),
        .push_i     (av),
        .pushData_i ({pushVec, rowCnt_q, rowLast}),
        .ready_i    (out_ready),
        .valid_o    (out_valid),
        .data_o     (fifoOut),
        .count_o    (fifo_count),
        .drop_o     (fifoDrop)
    );

    assign {out_data, out_row_idx, out_last} = fifoOut;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ctrl_result_deskew.sv
// Self-checking bench for ctrl_result_deskew: directed tables and sequences
// plus randomized traffic against a queue-based reference model.
module tb_ctrl_result_deskew;
    import ctrl_result_deskew_pkg::*;

    localparam int N  = NUM_PE_ROWS;
    localparam int BW = PARTIAL_SUM_BW;
    localparam int DW = VEC_W;
    localparam int M  = MATRIX_SIZE;
    localparam int D  = FIFO_DEPTH;

    logic                 clk = 1'b0;
    logic                 rstn, clr, in_valid, out_ready;
    logic [DW-1:0]        result;
    logic                 out_valid, out_last, overflow;
    logic [DW-1:0]        out_data;
    logic [ROW_IDX_W-1:0] out_row_idx;
    logic [CNT_W-1:0]     fifo_count;

    always #5 clk = ~clk;

    ctrl_result_deskew dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .in_valid    (in_valid),
        .result      (result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        bit            last;
    } entry_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    typedef struct {
        bit inV;
        bit rdy;
        bit expValid;
        int expCount;
        bit expOvf;
        int expRow;
    } tvec_t;

    entry_t        modelQ[$];
    pend_t         pendQ[$];
    int            modelRow;
    bit            modelOvf;
    int            cyc;
    logic [BW-1:0] sched [N][N];
    bit            schedV [N][N];
    int            checks = 0;
    int            errors = 0;
    tvec_t         tbl [17];

    // Compare one observed value against the bench's expectation.
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane-wise clamp applied to rows when the ReLU option is built in.
    function automatic logic [DW-1:0] reluVec(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
`ifdef RESULT_DESKEW_RELU_EN
        for (int l = 0; l < N; l++) begin
            logic [BW-1:0] x;
            x = v[l*BW +: BW];
            if (x[BW-1]) r[l*BW +: BW] = '0;
        end
`endif
        return r;
    endfunction

    function automatic logic [DW-1:0] rowPat(input int r);
        logic [DW-1:0] v;
        for (int l = 0; l < N; l++) v[l*BW +: BW] = BW'(r * 16 + l + 1);
        return v;
    endfunction

    function automatic logic [DW-1:0] randVec();
        logic [DW-1:0] v;
        for (int l = 0; l < N; l++) v[l*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    task automatic clearModel();
        modelQ.delete();
        pendQ.delete();
        modelRow = 0;
        modelOvf = 0;
        for (int d = 0; d < N; d++)
            for (int l = 0; l < N; l++) begin
                sched[d][l]  = '0;
                schedV[d][l] = 0;
            end
    endtask

    // Compare every DUT output with the model's FIFO head and flags.
    task automatic checkOutput();
        bit            expValid;
        logic [DW-1:0] expData;
        int            expRow;
        bit            expLast;
        expValid = (modelQ.size() > 0);
        expData  = expValid ? modelQ[0].data : '0;
        expRow   = expValid ? modelQ[0].row : 0;
        expLast  = expValid ? modelQ[0].last : 1'b0;
        check("out_valid", DW'(out_valid), DW'(expValid));
        check("out_data", out_data, expData);
        check("out_row_idx", DW'(out_row_idx), DW'(expRow));
        check("out_last", DW'(out_last), DW'(expLast));
        check("fifo_count", DW'(fifo_count), DW'(modelQ.size()));
        check("overflow", DW'(overflow), DW'(modelOvf));
    endtask

    // Drive one cycle: start a row if inV (its lanes skewed over the next cycles),
    // advance the model across the clock edge, then check outputs.
    task automatic applyStimulus(input bit inV, input bit rdy, input logic [DW-1:0] vec);
        bit            av, pop, spaceOk;
        logic [DW-1:0] avData;
        pend_t         p;
        in_valid  = inV;
        out_ready = rdy;
        if (inV) begin
            for (int l = 0; l < N; l++) begin
                sched[l][l]  = vec[l*BW +: BW];
                schedV[l][l] = 1;
            end
            pendQ.push_back('{due: cyc + N - 1, data: reluVec(vec)});
        end
        for (int l = 0; l < N; l++)
            result[l*BW +: BW] = schedV[0][l] ? sched[0][l] : BW'($urandom);
        av     = 0;
        avData = '0;
        if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
            p      = pendQ.pop_front();
            av     = 1;
            avData = p.data;
        end
        pop     = (modelQ.size() > 0) && rdy;
        spaceOk = (modelQ.size() < D) || pop;
        if (pop) void'(modelQ.pop_front());
        if (av) begin
            if (spaceOk) modelQ.push_back('{data: avData, row: modelRow, last: (modelRow == M - 1)});
            else         modelOvf = 1;
            modelRow = (modelRow + 1) % M;
        end
        for (int d = 0; d < N - 1; d++)
            for (int l = 0; l < N; l++) begin
                sched[d][l]  = sched[d+1][l];
                schedV[d][l] = schedV[d+1][l];
            end
        for (int l = 0; l < N; l++) begin
            sched[N-1][l]  = '0;
            schedV[N-1][l] = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic doClr();
        in_valid = 0;
        clr      = 1;
        @(posedge clk);
        #1;
        clr = 0;
        cyc++;
        clearModel();
        checkOutput();
    endtask

    task automatic doReset();
        in_valid = 0;
        rstn     = 0;
        #2;
        clearModel();
        checkOutput();
        @(posedge clk);
        #1;
        rstn = 1;
        cyc++;
    endtask

    initial begin
        logic [DW-1:0] expVec, vec;
        int            beatRow[$];
        int            beatLast[$];
        int            beatCyc[$];
        logic [BW-1:0] lane3;

        tbl = '{
            '{1,0,0,0,0,0}, '{1,0,0,0,0,0}, '{1,0,0,0,0,0}, '{1,0,0,0,0,0},
            '{1,0,0,0,0,0}, '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, '{0,0,1,1,0,0},
            '{0,0,1,2,0,0}, '{0,0,1,3,0,0}, '{0,0,1,4,0,0}, '{0,0,1,4,1,0},
            '{0,1,1,3,1,1}, '{0,1,1,2,1,2}, '{0,1,1,1,1,3}, '{0,1,0,0,1,0},
            '{0,1,0,0,1,0}
        };

        rstn      = 0;
        clr       = 0;
        in_valid  = 0;
        out_ready = 0;
        result    = '0;
        cyc       = 0;
        clearModel();
        #2;
        checkOutput();
        @(posedge clk);
        #1;
        rstn = 1;
        cyc++;

        // Single row: lane i carries i+1, arrives after N cycles.
        for (int l = 0; l < N; l++) expVec[l*BW +: BW] = BW'(l + 1);
        applyStimulus(1, 0, expVec);
        for (int k = 1; k < N; k++) begin
            if (k == N - 1) check("single_early_valid", DW'(out_valid), '0);
            applyStimulus(0, 0, '0);
        end
        check("single_valid", DW'(out_valid), DW'(1));
        check("single_data", out_data, expVec);
        check("single_row", DW'(out_row_idx), '0);
        check("single_last", DW'(out_last), '0);
        doClr();

        // Full tile plus one with the consumer always ready.
        for (int k = 0; k < 19; k++) begin
            applyStimulus(k < 9, 1, rowPat(k));
            if (out_valid) begin
                beatRow.push_back(int'(out_row_idx));
                beatLast.push_back(int'(out_last));
                beatCyc.push_back(cyc);
            end
        end
        check("tile_beats", DW'(beatRow.size()), DW'(9));
        for (int b = 0; b < beatRow.size(); b++) begin
            check("tile_row", DW'(beatRow[b]), DW'(b % M));
            check("tile_last", DW'(beatLast[b]), DW'(b == M - 1));
            check("tile_b2b", DW'(beatCyc[b]), DW'(beatCyc[0] + b));
        end
        doClr();

        // Backpressure table: five rows into a four-deep FIFO, then drain.
        for (int k = 0; k < 17; k++) begin
            applyStimulus(tbl[k].inV, tbl[k].rdy, rowPat(k));
            check("tbl_valid", DW'(out_valid), DW'(tbl[k].expValid));
            check("tbl_count", DW'(fifo_count), DW'(tbl[k].expCount));
            check("tbl_overflow", DW'(overflow), DW'(tbl[k].expOvf));
            check("tbl_row", DW'(out_row_idx), DW'(tbl[k].expRow));
            check("tbl_data", out_data, tbl[k].expValid ? rowPat(tbl[k].expRow) : '0);
        end
        doClr();

        // Full FIFO with a pop in the same cycle as the fifth arrival.
        for (int k = 0; k < 12; k++) applyStimulus(k < 5, k == 11, rowPat(k));
        check("fullpop_count", DW'(fifo_count), DW'(4));
        check("fullpop_overflow", DW'(overflow), '0);
        check("fullpop_row", DW'(out_row_idx), DW'(1));
        applyStimulus(0, 0, '0);
        check("fullpop_hold", DW'(fifo_count), DW'(4));
        doClr();

        // Async reset mid-stream discards in-flight rows.
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, rowPat(k));
        doReset();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 1, '0);
            check("rst_no_valid", DW'(out_valid), '0);
        end

        // Synchronous clear mid-stream does the same.
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, rowPat(k));
        doClr();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 1, '0);
            check("clr_no_valid", DW'(out_valid), '0);
        end

        // Negative lane handling.
        vec = rowPat(5);
        vec[3*BW +: BW] = 19'h7FFFB;
        applyStimulus(1, 0, vec);
        for (int k = 1; k < N; k++) applyStimulus(0, 0, '0);
        lane3 = out_data[3*BW +: BW];
`ifdef RESULT_DESKEW_RELU_EN
        check("relu_lane3", DW'(lane3), '0);
`else
        check("relu_lane3", DW'(lane3), DW'(19'h7FFFB));
`endif
        doClr();

        // Randomized traffic with shifting consumer readiness.
        for (int k = 0; k < 400; k++) begin
            int readyPct;
            readyPct = ((k / 50) % 2 == 0) ? 30 : 85;
            if (k == 200) doClr();
            applyStimulus($urandom_range(0, 99) < 65, $urandom_range(0, 99) < readyPct, randVec());
        end
        for (int k = 0; k < 20; k++) applyStimulus(0, 1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
